// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the commit trace monitor.
//   trace_entry_t        - one history slot {valid, pc, inst} at the default 32-bit width
//   DEFAULT_SENTINEL_PC  - PC value meaning "no instruction"
//   DEFAULT_HALT_EXEMPT  - PC where an all-zero instruction is not a halt
//   HALT_INST            - instruction word treated as halt
package trace_pkg;

  localparam int TRACE_XLEN = 32;

  localparam logic [TRACE_XLEN-1:0] DEFAULT_SENTINEL_PC = 32'h0000_0000;
  localparam logic [TRACE_XLEN-1:0] DEFAULT_HALT_EXEMPT = 32'h0040_0000;
  localparam logic [TRACE_XLEN-1:0] HALT_INST           = 32'h0000_0000;

  typedef struct packed {
    logic                  valid;
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] inst;
  } trace_entry_t;

endpackage

// File: rtl/trace_history_shift.sv
// trace_history_shift: DEPTH-entry shift register of trace entries.
//   clk     - system clock
//   reset   - asynchronous active-low reset, clears every entry
//   shift   - when high, din enters entry[0] and every entry moves one place
//   din     - entry loaded into slot 0 on a shift
//   evicted - current contents of the last slot, i.e. the entry leaving on the next shift
module trace_history_shift
  import trace_pkg::*;
#(
  parameter int  DEPTH   = 5,
  parameter type entry_t = trace_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   shift,
  input  entry_t din,
  output entry_t evicted
);

  entry_t hist [DEPTH];

  // NOTE: this array is reset on purpose; stale valid bits would otherwise
  // be reported as commits after reset, so it cannot be left as plain RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else if (shift) begin
      // NOTE: non-blocking assignments make every slot read its neighbour's
      // old value, so the loop order does not matter.
      hist[0] <= din;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  assign evicted = hist[DEPTH-1];

endmodule

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor: aligns fetch-stage PC/instruction pairs with write-back
// by delaying them DEPTH PC-change events, and reports one commit record per
// retired slot together with a commit count and sticky terminal flags.
//   clk, reset            - clock and asynchronous active-low reset
//   en                    - monitor enable; state holds while low
//   pc, inst              - current fetch PC and its instruction
//   commit_valid          - one-cycle pulse, commit_pc/commit_inst valid
//   commit_pc, commit_inst- record of the committing slot
//   commit_count          - saturating number of commits reported
//   done, halt, hang      - sticky: commit limit, halt committed, PC frozen
module commit_trace_monitor
  import trace_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              DEPTH          = 5,
  parameter int              MAX_COMMITS    = 1000,
  parameter int              CNT_W          = 16,
  parameter logic [XLEN-1:0] SENTINEL_PC    = XLEN'(DEFAULT_SENTINEL_PC),
  parameter bit              HALT_EN        = 1'b1,
  parameter logic [XLEN-1:0] HALT_EXEMPT_PC = XLEN'(DEFAULT_HALT_EXEMPT),
  parameter int              HANG_LIMIT     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  inst,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_pc,
  output logic [XLEN-1:0]  commit_inst,
  output logic [CNT_W-1:0] commit_count,
  output logic             done,
  output logic             halt,
  output logic             hang
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  localparam logic [XLEN-1:0]  HALT_WORD = XLEN'(HALT_INST);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_COMMITS);
  localparam logic [CNT_W-1:0] HANG_CNT  = CNT_W'(HANG_LIMIT);

  logic [XLEN-1:0]  last_pc;
  logic [CNT_W-1:0] hang_cnt;
  logic             frozen;
  logic             change;
  logic             stall;
  logic             commit_now;
  logic             is_halt;
  logic [CNT_W-1:0] count_inc;
  entry_t           new_entry;
  entry_t           evicted;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    new_entry       = '0;
    new_entry.valid = (pc != SENTINEL_PC);
    new_entry.pc    = pc;
    new_entry.inst  = inst;

    frozen     = done | halt | hang;
    change     = en && (pc != last_pc) && !frozen;
    stall      = en && (pc == last_pc) && !frozen;
    // Sentinel slots ride through the history but never retire.
    commit_now = change && evicted.valid;
    is_halt    = HALT_EN && (evicted.inst == HALT_WORD) &&
                 (evicted.pc != HALT_EXEMPT_PC);
    count_inc  = (commit_count == '1) ? commit_count : commit_count + 1'b1;
  end

  trace_history_shift #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_history (
    .clk     (clk),
    .reset   (reset),
    .shift   (change),
    .din     (new_entry),
    .evicted (evicted)
  );

  // Commit record, count and commit-driven flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc      <= SENTINEL_PC;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      commit_count <= '0;
      done         <= 1'b0;
      halt         <= 1'b0;
    end else begin
      commit_valid <= commit_now;
      if (change) last_pc <= pc;
      if (commit_now) begin
        commit_pc    <= evicted.pc;
        commit_inst  <= evicted.inst;
        commit_count <= count_inc;
        // done rises together with the commit that reaches the limit.
        if (count_inc == MAX_CNT) done <= 1'b1;
        if (is_halt)              halt <= 1'b1;
      end
    end
  end

  // Hang detection: consecutive enabled cycles with an unchanged PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hang_cnt <= '0;
      hang     <= 1'b0;
    end else if (change) begin
      hang_cnt <= '0;
    end else if (stall && (HANG_LIMIT != 0)) begin
      hang_cnt <= hang_cnt + 1'b1;
      if (hang_cnt + 1'b1 == HANG_CNT) hang <= 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_trace_monitor.sv
// tb_commit_trace_monitor: directed self-checking bench for commit_trace_monitor.
// Two instances share stimulus: dut (default parameters) and dut3 (MAX_COMMITS=3).
module tb_commit_trace_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] pc;
  logic [31:0] inst;

  logic        commit_valid,   d3_commit_valid;
  logic [31:0] commit_pc,      d3_commit_pc;
  logic [31:0] commit_inst,    d3_commit_inst;
  logic [15:0] commit_count,   d3_commit_count;
  logic        done,  halt,  hang;
  logic        d3_done, d3_halt, d3_hang;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_trace_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .pc           (pc),
    .inst         (inst),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .commit_count (commit_count),
    .done         (done),
    .halt         (halt),
    .hang         (hang)
  );

  commit_trace_monitor #(.MAX_COMMITS(3)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .pc           (pc),
    .inst         (inst),
    .commit_valid (d3_commit_valid),
    .commit_pc    (d3_commit_pc),
    .commit_inst  (d3_commit_inst),
    .commit_count (d3_commit_count),
    .done         (d3_done),
    .halt         (d3_halt),
    .hang         (d3_hang)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] p3_pc   [8] = '{32'h0040_0000, 32'h0040_0020, 32'h0040_0030, 32'h0040_0040,
                               32'h0040_0050, 32'h0040_0060, 32'h0040_0070, 32'h0040_0080};
  logic [31:0] p3_inst [8] = '{32'h0, 32'h0, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
  logic [31:0] p3_exp_pc   [7] = '{32'h20, 32'h24, 32'h28, 32'h10, 32'h14,
                                   32'h0040_0000, 32'h0040_0020};
  logic [31:0] p3_exp_inst [7] = '{32'h1008, 32'h1009, 32'h100a, 32'h2010, 32'h2014,
                                   32'h0, 32'h0};

  initial begin
    reset = 1'b0; en = 1'b0; pc = '0; inst = '0;
    tick(); tick();
    check("rst_valid", commit_valid, 1'b0);
    check("rst_pc",    commit_pc,    32'h0);
    check("rst_inst",  commit_inst,  32'h0);
    check("rst_count", commit_count, 16'h0);
    check("rst_flags", {done, halt, hang}, 3'b000);
    reset = 1'b1; en = 1'b1;

    // Phase 1: pc 4..40, one new PC every two cycles.
    for (int i = 1; i <= 10; i++) begin
      pc = 32'(4 * i); inst = 32'h1000 + 32'(i);
      tick();
      check("p1_valid", commit_valid, (i >= 6));
      if (i >= 6) begin
        check("p1_pc",   commit_pc,   32'(4 * (i - 5)));
        check("p1_inst", commit_inst, 32'h1000 + 32'(i - 5));
      end
      check("p1_d3_valid", d3_commit_valid, (i >= 6 && i <= 8));
      check("p1_d3_done",  d3_done,         (i >= 8));
      tick();
      check("p1_idle", commit_valid, 1'b0);
    end
    check("p1_count",    commit_count,    16'd5);
    check("p1_d3_count", d3_commit_count, 16'd3);

    // Phase 2: pc held at 0x10 for ten cycles.
    pc = 32'h10; inst = 32'h2010;
    tick();
    check("p2_pc0",    commit_pc,    32'd24);
    check("p2_count0", commit_count, 16'd6);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("p2_stall_valid", commit_valid, 1'b0);
      check("p2_stall_hang",  hang,         1'b0);
    end
    pc = 32'h14; inst = 32'h2014;
    tick();
    check("p2_valid1",  commit_valid, 1'b1);
    check("p2_pc1",     commit_pc,    32'd28);
    check("p2_count1",  commit_count, 16'd7);
    check("p2_d3_hold", {d3_commit_valid, d3_commit_count}, {1'b0, 16'd3});
    tick();

    // Phase 3: exempt all-zero instruction, then a real halt.
    for (int k = 0; k < 8; k++) begin
      pc = p3_pc[k]; inst = p3_inst[k];
      tick();
      if (k < 7) begin
        check("p3_valid", commit_valid, 1'b1);
        check("p3_pc",    commit_pc,    p3_exp_pc[k]);
        check("p3_inst",  commit_inst,  p3_exp_inst[k]);
        check("p3_count", commit_count, 16'(8 + k));
        check("p3_halt",  halt,         (k == 6));
      end else begin
        check("p3_frozen_valid", commit_valid, 1'b0);
        check("p3_frozen_pc",    commit_pc,    32'h0040_0020);
        check("p3_frozen_count", commit_count, 16'd14);
        check("p3_frozen_halt",  halt,         1'b1);
      end
      tick();
    end

    // Phase 4: asynchronous reset mid-cycle, then mid-stream after 3 commits.
    #3 reset = 1'b0;
    #1;
    check("r1_count", commit_count, 16'h0);
    check("r1_flags", {done, halt, hang, d3_done}, 4'b0000);
    check("r1_pc",    commit_pc,    32'h0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pc = 32'h200 + 32'(4 * k); inst = 32'h3000 + 32'(k);
      tick();
      check("r2_valid", commit_valid, (k >= 5));
      if (k >= 5) check("r2_pc", commit_pc, 32'h200 + 32'(4 * (k - 5)));
      tick();
    end
    check("r2_count", commit_count, 16'd3);
    #3 reset = 1'b0;
    #1;
    check("r3_count", commit_count, 16'h0);
    check("r3_pc",    commit_pc,    32'h0);
    check("r3_inst",  commit_inst,  32'h0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pc = 32'h300 + 32'(4 * k); inst = 32'h4000 + 32'(k);
      tick();
      check("r4_valid", commit_valid, (k == 5));
      if (k == 5) begin
        check("r4_pc",    commit_pc,    32'h300);
        check("r4_inst",  commit_inst,  32'h4000);
        check("r4_count", commit_count, 16'd1);
      end
      tick();
    end

    // Phase 5: enable low for 100 cycles, then PC frozen with enable high.
    en = 1'b0; pc = 32'h0040_0008; inst = 32'h88;
    for (int i = 0; i < 100; i++) tick();
    check("h0_hang",  hang,         1'b0);
    check("h0_count", commit_count, 16'd1);
    en = 1'b1;
    tick();
    check("h1_valid", commit_valid, 1'b1);
    check("h1_pc",    commit_pc,    32'h304);
    check("h1_count", commit_count, 16'd2);
    for (int i = 0; i < 63; i++) tick();
    check("h2_hang63", hang, 1'b0);
    tick();
    check("h3_hang64", hang, 1'b1);
    pc = 32'h500; inst = 32'h55;
    tick();
    check("h4_frozen_valid", commit_valid, 1'b0);
    check("h4_frozen_count", commit_count, 16'd2);
    check("h4_frozen_hang",  hang,         1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
